stream_pkt_fifo: RTL and testbench
==================================

# stream_pkt_fifo

Per-output packet buffer placed directly downstream of each `stream_xbar` master port. It absorbs the xbar's `m_data/m_id/m_last` beats into a `DEPTH`-entry synchronous FIFO and re-presents them on a valid/ready stream. This decouples xbar arbitration from slow sinks and keeps the xbar's grant from stalling on a back-pressured consumer. Optional store-and-forward mode releases a packet only once its `last` beat is buffered.

## Interface
Parameters:
- `T_DATA_WIDTH`, 8: data beat width.
- `T_ID___WIDTH`, 2: source-id width, equal to the xbar's `$clog2(S_DATA_COUNT)`.
- `DEPTH`, 8: number of entries. Power of two, ≥ 2.

Ports:
- `clk` in 1: single clock. All logic is sampled on its rising edge.
- `rst_n` in 1: reset. Synchronous, active-low.
- `s_data_i` in `T_DATA_WIDTH`: input beat data, from xbar `m_data_o[k]`.
- `s_id_i` in `T_ID___WIDTH`: source id of the beat.
- `s_last_i` in 1: last beat of the packet.
- `s_valid_i` in 1: input beat valid.
- `s_ready_o` out 1: buffer can accept a beat.
- `m_data_o` out `T_DATA_WIDTH`: head beat data.
- `m_id_o` out `T_ID___WIDTH`: head beat id.
- `m_last_o` out 1: head beat last flag.
- `m_valid_o` out 1: head beat valid.
- `m_ready_i` in 1: sink accepts the head beat.
- `count_o` out `$clog2(DEPTH+1)`: beats currently stored.
- `pkt_count_o` out `$clog2(DEPTH+1)`: complete packets stored, i.e. `last` beats held.
- `oversize_o` out 1: sticky flag. Store-and-forward mode only; tied to 0 otherwise.

## Operation
- Push: occurs on `s_valid_i && s_ready_o`. The beat `{last,id,data}` is written at `wr_ptr`, then `wr_ptr` increments.
- Pop: occurs on `m_valid_o && m_ready_i`. `rd_ptr` increments.
- Pointers are `$clog2(DEPTH)+1` bits. The extra MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - Wrap-around is natural modulo `2*DEPTH`.
- `s_ready_o = !full`. It is registered-state only, with no combinational path from `m_ready_i`. A pop at full does not allow a push in the same cycle.
- `count_o`:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- `pkt_count_o`:
  - +1 on a push with `s_last_i=1`.
  - −1 on a pop with `m_last_o=1`.
  - Both in one cycle: unchanged.
- Cut-through mode: `m_valid_o = !empty`.
- `m_*` outputs hold stable while `m_valid_o && !m_ready_i`.
- Reset, when `rst_n=0` at the edge:
  - Pointers, counts and `oversize_o` are cleared.
  - `s_ready_o` is 0 during reset and 1 from the first edge after release.
  - `m_valid_o`, `m_last_o`, `count_o` and `pkt_count_o` are 0.
  - `m_data_o` and `m_id_o` are don't-care while `m_valid_o=0`.
  - Reset in mid-packet discards all buffered beats, including partial packets. No beat is emitted after reset until a new push.

## Timing
- Write-to-read latency is 1 cycle. A beat pushed at edge N is visible with `m_valid_o=1` after edge N when the FIFO was empty.
- Throughput is 1 beat/cycle when not full and the sink is ready.
- In store-and-forward mode, the first beat of a packet is visible 1 cycle after its `last` beat is pushed.
- A push of `last` at edge N gives `pkt_count_o` incremented after edge N.
- Storage is flop-based with a combinational read of the head entry. No output register stage.

## Configuration
- Macro: `STREAM_PKT_FIFO_SAF_EN`.
- Defined (store-and-forward mode):
  - `m_valid_o = !empty && (pkt_count != 0 || full)`.
  - If full with `pkt_count == 0`, the packet is longer than `DEPTH`. The head is released in cut-through fashion to guarantee forward progress, and `oversize_o` is set sticky until reset.
- Undefined (cut-through mode): `oversize_o` is constant 0 and the `pkt_count` gate is absent. `pkt_count_o` is still maintained.

## Structure
- `stream_pkg` holds:
  - The default widths (`T_DATA_WIDTH`, `T_ID___WIDTH`).
  - The entry field layout constants: `last` at MSB, then id, then data at the LSBs.
  - The pointer-width helper function.
- Sub-module `stream_fifo_mem`: a `DEPTH` × (`T_DATA_WIDTH`+`T_ID___WIDTH`+1) flop array with one synchronous write port and one combinational read port. It has no reset.
- Top level: pointer, count and flag logic plus the valid gating.

## Test plan
- Reset, then idle: `s_ready_o=1`, `m_valid_o=0`, `count_o=0`. Assert `rst_n=0` with `s_valid_i=1`: no push occurs.
- Single 3-beat packet (data 0x11, 0x22, 0x33; id 2; last on the third beat) with `m_ready_i=1`:
  - Cut-through: each beat emerges 1 cycle after its push, in order.
  - Store-and-forward: 0x11 appears 1 cycle after 0x33 is pushed.
- Fill 8 single-beat packets with `m_ready_i=0`: `s_ready_o=0` after the 8th push, and `count_o=8`, `pkt_count_o=8`. A 9th beat is held upstream. Raise `m_ready_i`: all 8 beats drain in order, then the 9th.
- Simultaneous push and pop at `count_o=4` for 20 cycles with pointers wrapping: `count_o` stays 4 and data order is preserved.
- Store-and-forward mode, 10-beat packet with `DEPTH=8`: at full with `pkt_count_o=0`, `m_valid_o` rises and `oversize_o=1`. All 10 beats are delivered intact, and `oversize_o` stays 1 until reset.
- Reset asserted after beat 2 of a 4-beat packet: the next cycle shows `count_o=0` and `m_valid_o=0`. A fresh packet afterwards passes normally.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared widths, FIFO entry layout and pointer sizing for the stream buffering blocks.
package stream_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefIdWidth   = 2;

    // Entry layout: {last, id, data}, data at the LSBs.
    function automatic int unsigned entry_width(input int unsigned dw, input int unsigned iw);
        return dw + iw + 1;
    endfunction

    function automatic int unsigned last_pos(input int unsigned dw, input int unsigned iw);
        return dw + iw;
    endfunction

    function automatic int unsigned id_lsb(input int unsigned dw);
        return dw;
    endfunction

    // One extra bit above the address distinguishes full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Flop-array storage: one synchronous write port, one combinational read port, no reset.
module stream_fifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/stream_pkt_fifo.sv
// Per-port packet FIFO behind the stream crossbar; store-and-forward when
// STREAM_PKT_FIFO_SAF_EN is defined, cut-through otherwise.
module stream_pkt_fifo
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = DefDataWidth,
    parameter int unsigned T_ID___WIDTH = DefIdWidth,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [T_DATA_WIDTH-1:0]      s_data_i,
    input  logic [T_ID___WIDTH-1:0]      s_id_i,
    input  logic                         s_last_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    output logic [T_DATA_WIDTH-1:0]      m_data_o,
    output logic [T_ID___WIDTH-1:0]      m_id_o,
    output logic                         m_last_o,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count_o,
    output logic                         oversize_o
);

    localparam int unsigned EW      = entry_width(T_DATA_WIDTH, T_ID___WIDTH);
    localparam int unsigned PW      = ptr_width(DEPTH);
    localparam int unsigned AW      = PW - 1;
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam int unsigned LastBit = last_pos(T_DATA_WIDTH, T_ID___WIDTH);
    localparam int unsigned IdLsb   = id_lsb(T_DATA_WIDTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pkt_count_q, pkt_count_d;
    logic          ready_q;
    logic          empty, full, full_d;
    logic          push, pop, head_last, valid;
    logic [EW-1:0] wr_entry, rd_entry;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign head_last = rd_entry[LastBit];
    assign push      = s_valid_i && ready_q;
    assign pop       = valid && m_ready_i;
    assign wr_entry  = {s_last_i, s_id_i, s_data_i};

`ifdef STREAM_PKT_FIFO_SAF_EN
    logic oversize_q, oversize_d;

    // Full with no complete packet: release anyway so the upstream can finish the packet.
    assign valid = !empty && ((pkt_count_q != '0) || full);

    always_comb begin
        oversize_d = oversize_q;
        if (full_d && (pkt_count_d == '0)) begin
            oversize_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oversize_q <= 1'b0;
        end else begin
            oversize_q <= oversize_d;
        end
    end

    assign oversize_o = oversize_q;
`else
    assign valid      = !empty;
    assign oversize_o = 1'b0;
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pkt_count_d = pkt_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case ({push && s_last_i, pop && head_last})
            2'b10:   pkt_count_d = pkt_count_q + CW'(1);
            2'b01:   pkt_count_d = pkt_count_q - CW'(1);
            default: pkt_count_d = pkt_count_q;
        endcase

        full_d = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    end

    // Ready is registered from next-state fullness, so a pop at full never admits a push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_count_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pkt_count_q <= pkt_count_d;
            ready_q     <= !full_d;
        end
    end

    stream_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_entry),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_entry)
    );

    assign s_ready_o   = ready_q;
    assign m_valid_o   = valid;
    assign m_data_o    = rd_entry[T_DATA_WIDTH-1:0];
    assign m_id_o      = rd_entry[LastBit-1:IdLsb];
    assign m_last_o    = valid && head_last;
    assign count_o     = count_q;
    assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_stream_pkt_fifo.sv
// Scoreboard bench for stream_pkt_fifo; covers both modes via STREAM_PKT_FIFO_SAF_EN.
module tb_stream_pkt_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data_i;
    logic [1:0] s_id_i;
    logic       s_last_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic [7:0] m_data_o;
    logic [1:0] m_id_o;
    logic       m_last_o;
    logic       m_valid_o;
    logic       m_ready_i;
    logic [3:0] count_o;
    logic [3:0] pkt_count_o;
    logic       oversize_o;

    int total = 0;
    int bad   = 0;

    logic [10:0] exp_q[$];

`ifdef STREAM_PKT_FIFO_SAF_EN
    localparam bit Saf = 1'b1;
`else
    localparam bit Saf = 1'b0;
`endif

    always #5 clk = ~clk;

    stream_pkt_fifo #(
        .T_DATA_WIDTH (8),
        .T_ID___WIDTH (2),
        .DEPTH        (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data_i    (s_data_i),
        .s_id_i      (s_id_i),
        .s_last_i    (s_last_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .m_data_o    (m_data_o),
        .m_id_o      (m_id_o),
        .m_last_o    (m_last_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .count_o     (count_o),
        .pkt_count_o (pkt_count_o),
        .oversize_o  (oversize_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: one comparison per accepted output beat, plus stability while stalled.
    logic        hold_v = 1'b0;
    logic [10:0] hold_e;
    logic [10:0] beat_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_stable", {m_valid_o, m_last_o, m_id_o, m_data_o}, {1'b1, hold_e});
            end
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got=%0h expected=none", {m_last_o, m_id_o, m_data_o});
                end else begin
                    beat_e = exp_q.pop_front();
                    check("beat", {m_last_o, m_id_o, m_data_o}, beat_e);
                end
                hold_v = 1'b0;
            end else if (m_valid_o) begin
                hold_v = 1'b1;
                hold_e = {m_last_o, m_id_o, m_data_o};
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // Beat known to be accepted on the next edge.
    task automatic drive(input logic [7:0] d, input logic [1:0] id, input logic l);
        s_data_i  = d;
        s_id_i    = id;
        s_last_i  = l;
        s_valid_i = 1'b1;
        exp_q.push_back({l, id, d});
        @(negedge clk);
        check("drive_ready", s_ready_o, 1);
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
    endtask

    // Beat that may wait for space; bounded.
    task automatic push(input logic [7:0] d, input logic [1:0] id, input logic l);
        int n = 0;
        s_data_i  = d;
        s_id_i    = id;
        s_last_i  = l;
        s_valid_i = 1'b1;
        @(negedge clk);
        while (!s_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready_o) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got=ready0 expected=ready1 data=%0h", d);
        end else begin
            exp_q.push_back({l, id, d});
        end
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got=%0d left expected=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = 8'hee;
        s_id_i    = 2'd1;
        s_last_i  = 1'b1;
        m_ready_i = 1'b0;

        // Reset with valid held high: nothing may be pushed.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", s_ready_o, 0);
        check("rst_valid", m_valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_pkt", pkt_count_o, 0);
        s_valid_i = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready", s_ready_o, 1);
        check("idle_valid", m_valid_o, 0);
        check("idle_count", count_o, 0);
        check("idle_oversize", oversize_o, 0);

        // 3-beat packet, sink always ready.
        m_ready_i = 1'b1;
        drive(8'h11, 2'd2, 1'b0);
        check("lat_first_valid", m_valid_o, Saf ? 0 : 1);
        drive(8'h22, 2'd2, 1'b0);
        drive(8'h33, 2'd2, 1'b1);
        check("pkt_after_last", pkt_count_o, 1);
        check("valid_after_last", m_valid_o, 1);
        check("head_after_last", m_data_o, Saf ? 8'h11 : 8'h33);
        wait_drain();

        // Fill with 8 single-beat packets, sink stalled.
        m_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(8'h50 + 8'(i), 2'(i), 1'b1);
        end
        check("full_ready", s_ready_o, 0);
        check("full_count", count_o, 8);
        check("full_pkt", pkt_count_o, 8);
        fork
            push(8'h58, 2'd3, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("held_count", count_o, 8);
                m_ready_i = 1'b1;
            end
        join
        wait_drain();
        check("drained_pkt", pkt_count_o, 0);

        // Steady push+pop at count 4 across pointer wrap.
        m_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(8'h80 + 8'(i), 2'd1, 1'b1);
        end
        check("level4", count_o, 4);
        m_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(8'h90 + 8'(i), 2'd0, 1'b1);
            check("level_steady", count_o, 4);
        end
        wait_drain();

        // 10-beat packet longer than the FIFO.
        m_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(8'hc0 + 8'(i), 2'd1, i == 9);
            if (Saf && i == 7) begin
                check("ovs_full_count", count_o, 8);
                check("ovs_valid", m_valid_o, 1);
                check("ovs_flag", oversize_o, 1);
            end
        end
        wait_drain();
        check("ovs_sticky", oversize_o, Saf ? 1 : 0);

        // Reset in the middle of a packet.
        m_ready_i = 1'b0;
        drive(8'ha1, 2'd3, 1'b0);
        drive(8'ha2, 2'd3, 1'b0);
        check("mid_count", count_o, 2);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("mid_rst_count", count_o, 0);
        check("mid_rst_valid", m_valid_o, 0);
        check("mid_rst_pkt", pkt_count_o, 0);
        check("mid_rst_oversize", oversize_o, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", m_valid_o, 0);
        check("post_rst_ready", s_ready_o, 1);
        m_ready_i = 1'b1;
        drive(8'hb1, 2'd0, 1'b0);
        drive(8'hb2, 2'd0, 1'b1);
        wait_drain();
        check("final_count", count_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
